sdram_port_a_arbiter: RTL and testbench

- Shares the SDRAM controller's single untimed CPU-side port (port A: address, write, data in, data out) between NREQ requesters, e.g. CPU, cartridge/ROM loader and debug/DMA.
- Port A has no handshake. The controller samples it once per round, and a round is 10 clocks normally or 14 with refresh.
- The arbiter therefore holds each granted request stable for HOLD_CYCLES clocks. It then captures read data and returns a one-cycle ack.
- Sits between the requesters and the SDRAM controller in the top level.

---
 rtl/sdram_pkg.sv | 16 +
 rtl/rr_picker.sv | 49 ++++
 rtl/sdram_port_a_arbiter.sv | 122 ++++++++++++
 tb/tb_sdram_port_a_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for SDRAM port arbiters: FSM state encoding and
// controller round-length constants used to size the grant hold time.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // The controller samples port A once per round; refresh stretches the round.
  localparam int ROUND_NORMAL        = 10;
  localparam int ROUND_REFRESH       = 14;
  localparam int HOLD_CYCLES_DEFAULT = 2 * ROUND_REFRESH;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection with optional absolute priority
// for requester 0; shared by the port A arbiter and the video/DMA arbiter.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  input  logic             prio_mode_i,
  output logic             valid_o,
  output logic [NREQ-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] above_last;
  logic [NREQ-1:0] cand;

  // Requesters above last_grant get first pick; if none, wrap to the lowest.
  always_comb begin
    eligible    = req_i;
    above_last  = '0;
    cand        = '0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      above_last[i] = (i > int'(last_grant_i));
    end
    if (prio_mode_i) begin
      eligible[0] = 1'b0;
    end
    if (prio_mode_i && req_i[0]) begin
      cand[0] = 1'b1;
    end else if (|(eligible & above_last)) begin
      cand = eligible & above_last;
    end else begin
      cand = eligible;
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_idx_o   = IDX_W'(i);
        grant_oh_o    = '0;
        grant_oh_o[i] = 1'b1;
      end
    end
    valid_o = |cand;
  end

endmodule

// File: rtl/sdram_port_a_arbiter.sv
// Shares the untimed SDRAM port A among NREQ requesters, holding each grant
// long enough for a full controller round. Define SDRAM_ARB_CPU_PRIORITY_EN
// to give requester 0 absolute priority.
module sdram_port_a_arbiter
  import sdram_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        A_address,
  output logic                     A_write,
  output logic [DATA_W-1:0]        A_data_in,
  input  logic [DATA_W-1:0]        A_data_out
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);

`ifdef SDRAM_ARB_CPU_PRIORITY_EN
  localparam logic CPU_PRIO = 1'b1;
`else
  localparam logic CPU_PRIO = 1'b0;
`endif

  arb_state_e         state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NREQ-1:0]    grant_oh_q;
  logic [NREQ-1:0]    ack_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               busy_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               win_valid;
  logic [NREQ-1:0]    win_oh;
  logic [IDX_W-1:0]   win_idx;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .prio_mode_i  (CPU_PRIO),
    .valid_o      (win_valid),
    .grant_oh_o   (win_oh),
    .grant_idx_o  (win_idx)
  );

  // Port A has no handshake, so the grant is frozen for the whole hold window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      cnt_q        <= '0;
      grant_oh_q   <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          write_q <= 1'b0;
          if (win_valid) begin
            addr_q     <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            write_q    <= req_we[win_idx];
            wdata_q    <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            cnt_q      <= CNT_W'(HOLD_CYCLES - 1);
            busy_q     <= 1'b1;
            grant_oh_q <= win_oh;
            if (!(CPU_PRIO && (win_idx == '0))) begin
              last_grant_q <= win_idx;
            end
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            rdata_q <= A_data_out;
            write_q <= 1'b0;
            ack_q   <= grant_oh_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign A_address = addr_q;
  assign A_write   = write_q;
  assign A_data_in = wdata_q;

endmodule

// File: tb/tb_sdram_port_a_arbiter.sv
// Self-checking bench for sdram_port_a_arbiter with a round-based SDRAM
// controller model on port A and a transaction-level expectation model.
module tb_sdram_port_a_arbiter;
  import sdram_pkg::*;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int HOLD   = HOLD_CYCLES_DEFAULT;

`ifdef SDRAM_ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                   clk;
  logic                   reset_n;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [ADDR_W-1:0]      A_address;
  logic                   A_write;
  logic [DATA_W-1:0]      A_data_in;
  logic [DATA_W-1:0]      A_data_out;

  int checks = 0;
  int passes = 0;

  sdram_port_a_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .busy(busy), .A_address(A_address), .A_write(A_write),
    .A_data_in(A_data_in), .A_data_out(A_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: actual=no ack expected=ack within budget at %0t", name, $time);
  endtask

  // Controller emulation: samples port A at the start of each round, returns read data 3 clocks later.
  logic [DATA_W-1:0] mem [256];
  int          rc = 0;
  int          roundLen = ROUND_NORMAL;
  int          refreshReqs = 0;
  int          refreshDone = 0;
  bit          preloaded = 1'b0;
  logic [7:0]  pendAddr = '0;
  bit          pendValid = 1'b0;
  initial A_data_out = '0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h23] <= 16'hBEEF;
      mem[8'hAA] <= 16'h1234;
      preloaded  <= 1'b1;
    end else begin
      if (rc == 0) begin
        if (refreshDone != refreshReqs) begin
          roundLen    <= ROUND_REFRESH;
          refreshDone <= refreshDone + 1;
        end else begin
          roundLen <= ROUND_NORMAL;
        end
        if (A_write) mem[A_address[7:0]] <= A_data_in;
        else begin
          pendAddr  <= A_address[7:0];
          pendValid <= 1'b1;
        end
      end
      if (rc == 3 && pendValid) begin
        A_data_out <= mem[pendAddr];
        pendValid  <= 1'b0;
      end
    end
    rc <= (rc >= roundLen - 1) ? 0 : rc + 1;
  end

  // Transaction model: a grant lives for HOLD+2 clocks counted from its arbitration edge.
  bit                mActive;
  int                mK;
  int                mWin;
  int                mLast;
  logic              mWe;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWdata;
  logic [DATA_W-1:0] expRdata;

  function automatic int pickWinner(input logic [NREQ-1:0] r, input int last);
    int c;
    if (PRIO && r[0]) return 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (r[c] && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mActive  <= 1'b0;
      mK       <= 0;
      mWin     <= 0;
      mLast    <= NREQ - 1;
      mWe      <= 1'b0;
      expAddr  <= '0;
      expWdata <= '0;
      expRdata <= '0;
    end else if (!mActive) begin
      if (pickWinner(req, mLast) >= 0) begin
        mActive  <= 1'b1;
        mK       <= 0;
        mWin     <= pickWinner(req, mLast);
        mWe      <= req_we[pickWinner(req, mLast)];
        expAddr  <= req_addr[pickWinner(req, mLast)*ADDR_W +: ADDR_W];
        expWdata <= req_wdata[pickWinner(req, mLast)*DATA_W +: DATA_W];
        if (!(PRIO && pickWinner(req, mLast) == 0)) mLast <= pickWinner(req, mLast);
      end
    end else begin
      mK <= mK + 1;
      if (mK + 1 == HOLD) expRdata <= A_data_out;
      if (mK + 1 > HOLD) mActive <= 1'b0;
    end
  end

  function automatic logic [NREQ-1:0] expAck();
    logic [NREQ-1:0] a;
    a = '0;
    if (mActive && mK == HOLD) a[mWin] = 1'b1;
    return a;
  endfunction

  // Every cycle, 2 time units after the active edge, outputs must match the model.
  always @(posedge clk) begin
    #2;
    checkOutput("ack",       32'(ack),       32'(expAck()));
    checkOutput("busy",      32'(busy),      32'(mActive));
    checkOutput("A_write",   32'(A_write),   32'(mActive && mK < HOLD && mWe));
    checkOutput("A_address", 32'(A_address), 32'(expAddr));
    checkOutput("A_data_in", 32'(A_data_in), 32'(expWdata));
    checkOutput("rdata",     32'(rdata),     32'(expRdata));
  end

  task automatic applyStimulus(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    req_we[idx]                      = we;
    req_addr[idx*ADDR_W +: ADDR_W]   = addr;
    req_wdata[idx*DATA_W +: DATA_W]  = wdata;
    req[idx]                         = 1'b1;
  endtask

  task automatic runReq(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int dropAt, input int refreshAt,
                        output int lat, output logic [NREQ-1:0] ackSeen, output int writeCycles,
                        output logic [ADDR_W-1:0] addrAt1, output logic writeAt1);
    applyStimulus(idx, we, addr, wdata);
    lat = 0; ackSeen = '0; writeCycles = 0; addrAt1 = '0; writeAt1 = 1'b0;
    while (ackSeen == '0 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin addrAt1 = A_address; writeAt1 = A_write; end
      if (lat == dropAt) req[idx] = 1'b0;
      if (lat == refreshAt) refreshReqs++;
      if (A_write && A_data_in == wdata && A_address == addr) writeCycles++;
      ackSeen = ack;
    end
    req[idx] = 1'b0;
    if (ackSeen == '0) failNow("runReq_ack");
  endtask

  task automatic waitAnyAck(input int budget, output int lat, output logic [NREQ-1:0] a);
    lat = 0; a = '0;
    while (a == '0 && lat < budget) begin
      @(negedge clk);
      lat++;
      a = ack;
    end
    if (a == '0) failNow("waitAnyAck");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int                lat;
  int                wc;
  logic [NREQ-1:0]   a;
  logic [ADDR_W-1:0] a1;
  logic              w1;
  int                lastTime;
  logic [NREQ-1:0]   order [7];

  initial begin
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_A_write", 32'(A_write), 32'h0);
    checkOutput("reset_A_address", 32'(A_address), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single read");
    runReq(0, 1'b0, 24'h000123, 16'h0000, 0, 0, lat, a, wc, a1, w1);
    checkOutput("read_addr_at1", 32'(a1), 32'h000123);
    checkOutput("read_write_at1", 32'(w1), 32'h0);
    checkOutput("read_latency", 32'(lat), 32'd29);
    checkOutput("read_ack", 32'(a), 32'b001);
    checkOutput("read_rdata", 32'(rdata), 32'hBEEF);
    repeat (2) @(negedge clk);

    $display("[TB] write then read back");
    runReq(1, 1'b1, 24'h3FFFFF, 16'h5A5A, 0, 0, lat, a, wc, a1, w1);
    checkOutput("write_held_cycles", 32'(wc), 32'd28);
    checkOutput("write_ack", 32'(a), 32'b010);
    checkOutput("write_latency", 32'(lat), 32'd29);
    repeat (2) @(negedge clk);
    runReq(0, 1'b0, 24'h3FFFFF, 16'h0000, 0, 0, lat, a, wc, a1, w1);
    checkOutput("readback_ack", 32'(a), 32'b001);
    checkOutput("readback_rdata", 32'(rdata), 32'h5A5A);
    repeat (2) @(negedge clk);

    $display("[TB] refresh round during hold");
    runReq(2, 1'b0, 24'h0000AA, 16'h0000, 0, 2, lat, a, wc, a1, w1);
    checkOutput("refresh_ack", 32'(a), 32'b100);
    checkOutput("refresh_latency", 32'(lat), 32'd29);
    checkOutput("refresh_rdata", 32'(rdata), 32'h1234);
    repeat (2) @(negedge clk);

    $display("[TB] request dropped mid-hold");
    runReq(0, 1'b0, 24'h000123, 16'h0000, 6, 0, lat, a, wc, a1, w1);
    checkOutput("dropped_latency", 32'(lat), 32'd29);
    checkOutput("dropped_ack", 32'(a), 32'b001);
    checkOutput("dropped_rdata", 32'(rdata), 32'hBEEF);
    repeat (4) begin
      @(negedge clk);
      checkOutput("dropped_no_regrant", 32'(busy), 32'h0);
    end

    $display("[TB] reset during write hold");
    applyStimulus(1, 1'b1, 24'h000200, 16'h7777);
    repeat (11) @(negedge clk);
    checkOutput("midreset_write_before", 32'(A_write), 32'h1);
    reset_n = 1'b0;
    req = '0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_A_write", 32'(A_write), 32'h0);
    checkOutput("midreset_ack", 32'(ack), 32'h0);
    @(negedge clk);
    req_we = '0;
    req_addr[1*ADDR_W +: ADDR_W] = 24'h000300;
    req_addr[2*ADDR_W +: ADDR_W] = 24'h000400;
    req = 3'b110;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset_grant_addr", 32'(A_address), 32'h000300);
    waitAnyAck(40, lat, a);
    checkOutput("postreset_ack", 32'(a), 32'b010);
    checkOutput("postreset_latency", 32'(lat), 32'd28);
    req[1] = 1'b0;
    waitAnyAck(40, lat, a);
    checkOutput("postreset_second_ack", 32'(a), 32'b100);
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] contention from reset");
    reset_n = 1'b0;
    req_we = '0;
    req_addr = {24'h000012, 24'h000011, 24'h000010};
    req = 3'b111;
    @(negedge clk);
    reset_n = 1'b1;
`ifdef SDRAM_ARB_CPU_PRIORITY_EN
    order = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
`else
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`endif
    lastTime = 0;
    for (int n = 0; n < 7; n++) begin
      waitAnyAck(40, lat, a);
      checkOutput($sformatf("contention_ack%0d", n), 32'(a), 32'(order[n]));
      checkOutput($sformatf("contention_gap%0d", n), 32'(lat), (n == 0) ? 32'd29 : 32'd30);
      if (PRIO && n == 2) req[0] = 1'b0;
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
